// File: rtl/pico_gpio_irq.sv
// GPIO peripheral for the PicoRV32 native bus: synchronised inputs, atomic output
// updates, per-pin edge interrupts with write-one-to-clear status.
module pico_gpio_irq #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             busin_valid,
    input  logic [31:0]      busin_addr,
    input  logic [31:0]      busin_wdata,
    input  logic [3:0]       busin_wstrb,
    output logic             busout_ready,
    output logic [31:0]      busout_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [3:0] REG_OE      = 4'h0;
    localparam logic [3:0] REG_OUT     = 4'h1;
    localparam logic [3:0] REG_IN      = 4'h2;
    localparam logic [3:0] REG_OUT_SET = 4'h3;
    localparam logic [3:0] REG_OUT_CLR = 4'h4;
    localparam logic [3:0] REG_OUT_TGL = 4'h5;
    localparam logic [3:0] REG_RISE_EN = 4'h6;
    localparam logic [3:0] REG_FALL_EN = 4'h7;
    localparam logic [3:0] REG_STATUS  = 4'h8;

    logic [WIDTH-1:0] oe_reg;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] wval;
    logic [WIDTH-1:0] clr;
    logic [31:0]      lane_mask_full;
    logic [31:0]      wval_full;
    logic [31:0]      rd_val;
    logic [3:0]       idx;
    logic             access;
    logic             wr;
    logic             unused_bits;

    assign idx    = busin_addr[5:2];
    assign access = busin_valid && !busout_ready;
    assign wr     = |busin_wstrb;

    // Writes of every kind (plain, set/clear/toggle, W1C) are confined to strobed bytes.
    assign lane_mask_full = {{8{busin_wstrb[3]}}, {8{busin_wstrb[2]}},
                             {8{busin_wstrb[1]}}, {8{busin_wstrb[0]}}};
    assign wval_full      = busin_wdata & lane_mask_full;
    assign lane_mask      = lane_mask_full[WIDTH-1:0];
    assign wval           = wval_full[WIDTH-1:0];

    assign unused_bits = ^{busin_addr[31:6], busin_addr[1:0], wval_full, lane_mask_full};

    assign sync = sync_chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
    assign clr  = (access && wr && idx == REG_STATUS) ? wval : '0;

    assign gpio_out = out_reg;
    assign gpio_oe  = oe_reg;
    assign irq      = |status;

    always_comb begin
        rd_val = '0;
        case (idx)
            REG_OE:      rd_val = 32'(oe_reg);
            REG_OUT:     rd_val = 32'(out_reg);
            REG_IN:      rd_val = 32'(sync);
            REG_RISE_EN: rd_val = 32'(rise_en);
            REG_FALL_EN: rd_val = 32'(fall_en);
            REG_STATUS:  rd_val = 32'(status);
            default:     rd_val = '0;
        endcase
    end

    // A fresh edge on a bit being cleared in the same cycle keeps that bit set.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            oe_reg       <= '0;
            out_reg      <= '0;
            rise_en      <= '0;
            fall_en      <= '0;
            status       <= '0;
            prev         <= '0;
            busout_ready <= 1'b0;
            busout_rdata <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= '0;
        end else begin
            sync_chain[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
            prev   <= sync;
            status <= (status & ~clr) | (rise & rise_en) | (fall & fall_en);

            if (access) begin
                busout_ready <= 1'b1;
                busout_rdata <= rd_val;
                if (wr) begin
                    case (idx)
                        REG_OE:      oe_reg  <= (oe_reg & ~lane_mask) | wval;
                        REG_OUT:     out_reg <= (out_reg & ~lane_mask) | wval;
                        REG_OUT_SET: out_reg <= out_reg | wval;
                        REG_OUT_CLR: out_reg <= out_reg & ~wval;
                        REG_OUT_TGL: out_reg <= out_reg ^ wval;
                        REG_RISE_EN: rise_en <= (rise_en & ~lane_mask) | wval;
                        REG_FALL_EN: fall_en <= (fall_en & ~lane_mask) | wval;
                        default: ;
                    endcase
                end
            end else begin
                busout_ready <= 1'b0;
                busout_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pico_gpio_irq.sv
// Directed bench for pico_gpio_irq: a 32-pin instance for the register, edge and
// W1C behaviour, and an 8-pin instance for width truncation and reset mid-access.
module tb_pico_gpio_irq;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        resetn8 = 1'b0;
    logic        valid32 = 1'b0;
    logic        valid8 = 1'b0;
    logic [31:0] busin_addr = '0;
    logic [31:0] busin_wdata = '0;
    logic [3:0]  busin_wstrb = '0;
    logic [31:0] gpio_in = '0;

    logic        ready32, ready8, irq32, irq8;
    logic [31:0] rdata32, rdata8, gpio_out32, gpio_oe32;
    logic [7:0]  gpio_out8, gpio_oe8;

    int total = 0;
    int bad = 0;

    pico_gpio_irq #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
        .clk(clk), .resetn(resetn), .busin_valid(valid32), .busin_addr(busin_addr),
        .busin_wdata(busin_wdata), .busin_wstrb(busin_wstrb), .busout_ready(ready32),
        .busout_rdata(rdata32), .gpio_in(gpio_in), .gpio_out(gpio_out32),
        .gpio_oe(gpio_oe32), .irq(irq32)
    );

    pico_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .resetn(resetn8), .busin_valid(valid8), .busin_addr(busin_addr),
        .busin_wdata(busin_wdata), .busin_wstrb(busin_wstrb), .busout_ready(ready8),
        .busout_rdata(rdata8), .gpio_in(gpio_in[7:0]), .gpio_out(gpio_out8),
        .gpio_oe(gpio_oe8), .irq(irq8)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic [31:0] exp_out;
        logic [31:0] exp_oe;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One complete bus access; returns the data delivered with the ready pulse.
    task automatic applyStimulus(input bit use8, input logic [3:0] idx, input logic [31:0] wd,
                                 input logic [3:0] ws, output logic [31:0] rd);
        busin_addr  = BASE | {26'd0, idx, 2'b00};
        busin_wdata = wd;
        busin_wstrb = ws;
        if (use8) valid8 = 1'b1;
        else valid32 = 1'b1;
        @(posedge clk); #1;
        rd = use8 ? rdata8 : rdata32;
        checkOutput("ready_pulse", {31'd0, use8 ? ready8 : ready32}, 32'd1);
        valid8      = 1'b0;
        valid32     = 1'b0;
        busin_wstrb = '0;
        @(posedge clk); #1;
        checkOutput("ready_drop", {31'd0, use8 ? ready8 : ready32}, 32'd0);
        checkOutput("rdata_clear", use8 ? rdata8 : rdata32, 32'd0);
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;

        // Reset reads of all registers plus the unused window.
        for (int i = 0; i < 11; i++)
            vecs[i] = '{idx: (i < 9) ? 4'(i) : ((i == 9) ? 4'h9 : 4'hF),
                        wdata: 32'd0, wstrb: 4'h0, exp_rdata: 32'd0, exp_out: 32'd0, exp_oe: 32'd0};
        vecs[11] = '{4'h1, 32'hA5A5_A5A5, 4'b0101, 32'h0000_0000, 32'h00A5_00A5, 32'd0};
        vecs[12] = '{4'h1, 32'h0,         4'h0,    32'h00A5_00A5, 32'h00A5_00A5, 32'd0};
        vecs[13] = '{4'h1, 32'h0000_FF00, 4'hF,    32'h00A5_00A5, 32'h0000_FF00, 32'd0};
        vecs[14] = '{4'h3, 32'h0000_000F, 4'hF,    32'h0,         32'h0000_FF0F, 32'd0};
        vecs[15] = '{4'h4, 32'h0000_0F00, 4'hF,    32'h0,         32'h0000_F00F, 32'd0};
        vecs[16] = '{4'h5, 32'hFFFF_FFFF, 4'hF,    32'h0,         32'hFFFF_0FF0, 32'd0};
        vecs[17] = '{4'h1, 32'h0,         4'h0,    32'hFFFF_0FF0, 32'hFFFF_0FF0, 32'd0};
        vecs[18] = '{4'h3, 32'hFFFF_FFFF, 4'b0010, 32'h0,         32'hFFFF_FFF0, 32'd0};
        vecs[19] = '{4'h4, 32'hFFFF_FFFF, 4'b1000, 32'h0,         32'h00FF_FFF0, 32'd0};
        vecs[20] = '{4'h2, 32'h1234_5678, 4'hF,    32'h0,         32'h00FF_FFF0, 32'd0};
        vecs[21] = '{4'h0, 32'h0000_FFFF, 4'hF,    32'h0,         32'h00FF_FFF0, 32'h0000_FFFF};
        vecs[22] = '{4'h9, 32'hFFFF_FFFF, 4'hF,    32'h0,         32'h00FF_FFF0, 32'h0000_FFFF};
        vecs[23] = '{4'h0, 32'h0,         4'hF,    32'h0000_FFFF, 32'h00FF_FFF0, 32'h0};

        waitCycles(3);
        checkOutput("reset_ready", {31'd0, ready32}, 32'd0);
        checkOutput("reset_rdata", rdata32, 32'd0);
        checkOutput("reset_out", gpio_out32, 32'd0);
        checkOutput("reset_oe", gpio_oe32, 32'd0);
        checkOutput("reset_irq", {31'd0, irq32}, 32'd0);
        resetn  = 1'b1;
        resetn8 = 1'b1;
        waitCycles(1);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(1'b0, vecs[i].idx, vecs[i].wdata, vecs[i].wstrb, rd);
            checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_out", i), gpio_out32, vecs[i].exp_out);
            checkOutput($sformatf("vec%0d_oe", i), gpio_oe32, vecs[i].exp_oe);
            checkOutput($sformatf("vec%0d_irq", i), {31'd0, irq32}, 32'd0);
        end

        // Valid held high: ready alternates 1,0,1,0.
        busin_addr = BASE | 32'h4;
        busin_wstrb = '0;
        valid32 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("held_ready%0d", k), {31'd0, ready32}, (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("held_rdata%0d", k), rdata32, (k % 2 == 0) ? 32'h00FF_FFF0 : 32'd0);
        end
        valid32 = 1'b0;
        waitCycles(1);

        // Edge detection with gpio_in[1] already high before the enables go in.
        gpio_in = 32'h2;
        waitCycles(4);
        applyStimulus(1'b0, 4'h6, 32'h1, 4'hF, rd);
        applyStimulus(1'b0, 4'h7, 32'h2, 4'hF, rd);
        checkOutput("no_event_for_held_level", {31'd0, irq32}, 32'd0);

        gpio_in = 32'h3;
        waitCycles(1);
        checkOutput("irq_edge1", {31'd0, irq32}, 32'd0);
        waitCycles(1);
        checkOutput("irq_edge2", {31'd0, irq32}, 32'd0);
        busin_addr = BASE | 32'h8;
        busin_wstrb = '0;
        valid32 = 1'b1;
        @(posedge clk); #1;
        checkOutput("in_ready", {31'd0, ready32}, 32'd1);
        checkOutput("in_after_sync", rdata32, 32'h3);
        checkOutput("irq_edge3", {31'd0, irq32}, 32'd1);
        valid32 = 1'b0;
        waitCycles(1);
        applyStimulus(1'b0, 4'h8, 32'h0, 4'h0, rd);
        checkOutput("status_rise0", rd, 32'h1);

        gpio_in = 32'h1;
        waitCycles(4);
        applyStimulus(1'b0, 4'h8, 32'h0, 4'h0, rd);
        checkOutput("status_fall1", rd, 32'h3);
        gpio_in = 32'h3;
        waitCycles(4);
        applyStimulus(1'b0, 4'h8, 32'h0, 4'h0, rd);
        checkOutput("status_rise1_ignored", rd, 32'h3);

        // W1C racing a new rise on bit 0: the rise lands on the same edge as the write.
        gpio_in = 32'h2;
        waitCycles(4);
        gpio_in = 32'h3;
        waitCycles(2);
        applyStimulus(1'b0, 4'h8, 32'h1, 4'hF, rd);
        checkOutput("w1c_race_prewrite", rd, 32'h3);
        applyStimulus(1'b0, 4'h8, 32'h0, 4'h0, rd);
        checkOutput("w1c_race_status", rd, 32'h3);
        applyStimulus(1'b0, 4'h8, 32'h3, 4'b0010, rd);
        applyStimulus(1'b0, 4'h8, 32'h0, 4'h0, rd);
        checkOutput("w1c_lane_masked", rd, 32'h3);
        applyStimulus(1'b0, 4'h8, 32'h3, 4'hF, rd);
        checkOutput("w1c_irq_clear", {31'd0, irq32}, 32'd0);
        applyStimulus(1'b0, 4'h8, 32'h0, 4'h0, rd);
        checkOutput("w1c_status_clear", rd, 32'h0);

        // Narrow instance: bits above WIDTH read zero; reset drops a pending write.
        applyStimulus(1'b1, 4'h0, 32'hFFFF_FFFF, 4'hF, rd);
        checkOutput("w8_oe_pin", {24'd0, gpio_oe8}, 32'h0000_00FF);
        applyStimulus(1'b1, 4'h0, 32'h0, 4'h0, rd);
        checkOutput("w8_oe_read", rd, 32'h0000_00FF);

        busin_addr  = BASE | 32'h4;
        busin_wdata = 32'h0000_005A;
        busin_wstrb = 4'hF;
        valid8  = 1'b1;
        resetn8 = 1'b0;
        @(posedge clk); #1;
        checkOutput("w8_reset_ready", {31'd0, ready8}, 32'd0);
        checkOutput("w8_reset_out", {24'd0, gpio_out8}, 32'd0);
        valid8  = 1'b0;
        resetn8 = 1'b1;
        busin_wstrb = '0;
        @(posedge clk); #1;
        checkOutput("w8_after_reset_ready", {31'd0, ready8}, 32'd0);
        applyStimulus(1'b1, 4'h1, 32'h0, 4'h0, rd);
        checkOutput("w8_out_dropped", rd, 32'h0);
        applyStimulus(1'b1, 4'h0, 32'h0, 4'h0, rd);
        checkOutput("w8_oe_reset", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
